// File: rtl/iob_axistream_out_pkt.sv
// -----------------------------------------------------------------------------
// iob_axistream_out_pkt
//   CPU-to-AXI-Stream egress bridge. The CPU writes DATA_W-bit words through the
//   IOb native slave port. Each word is split into N = DATA_W/TDATA_W beats,
//   least significant beat first. The beats are buffered in a FIFO and sent out
//   through a single AXIS output register. tlast is generated by a programmable
//   packet-length counter. The bridge also provides level/threshold status, a
//   level-sensitive irq, a sticky overflow flag and a soft flush.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     iob_avalid/addr/    CPU request. A nonzero wstrb is a write and a zero
//     wdata/wstrb         wstrb is a read.
//     iob_rvalid/rdata    read response, returned one cycle after the request
//     iob_ready           always 1
//     tdata/tvalid/       AXIS master
//     tready/tlast
//     irq                 registered (level >= THRESH)
//
//   Register map (word addresses)
//     0 DATA (W)
//     1 PKT_LEN (W/R)
//     2 THRESH (W/R)
//     3 STATUS (R) = {overflow, pkt_busy, full, empty, level}
//     4 FLUSH (W)
// -----------------------------------------------------------------------------
module iob_axistream_out_pkt #(
  parameter int DATA_W          = 32,
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PKT_LEN_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iob_avalid,
  input  logic [2:0]            iob_addr,
  input  logic [DATA_W-1:0]     iob_wdata,
  input  logic [DATA_W/8-1:0]   iob_wstrb,
  output logic                  iob_rvalid,
  output logic [DATA_W-1:0]     iob_rdata,
  output logic                  iob_ready,
  output logic [TDATA_W-1:0]    tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic                  irq
);

  localparam int N     = DATA_W / TDATA_W;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int ST_W  = LVL_W + 4;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_PKT_LEN = 3'd1;
  localparam logic [2:0] ADDR_THRESH  = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_FLUSH   = 3'd4;

  function automatic logic [ST_W-1:0] pack_status(input logic             ovf,
                                                  input logic             busy,
                                                  input logic             full_f,
                                                  input logic             empty_f,
                                                  input logic [LVL_W-1:0] lvl);
    return {ovf, busy, full_f, empty_f, lvl};
  endfunction

  logic [TDATA_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]           fifo_cnt, level, free_beats;
  logic [LVL_W-1:0]           thresh;
  logic [PKT_LEN_W-1:0]       pkt_len, beat_cnt, beat_cnt_nxt;
  logic                       overflow, pkt_busy, full, empty;
  logic                       wr_en, rd_en, data_wr, push, drop;
  logic                       pkt_wr, pkt_rej, thresh_wr, flush, status_rd;
  logic                       hs, load, last_nxt;
  logic [DATA_W-1:0]          rd_mux;

  assign iob_ready = 1'b1;

  assign wr_en     = iob_avalid & (|iob_wstrb);
  assign rd_en     = iob_avalid & ~(|iob_wstrb);
  assign data_wr   = wr_en & (iob_addr == ADDR_DATA);
  assign pkt_wr    = wr_en & (iob_addr == ADDR_PKT_LEN);
  assign thresh_wr = wr_en & (iob_addr == ADDR_THRESH);
  assign flush     = wr_en & (iob_addr == ADDR_FLUSH);
  assign status_rd = rd_en & (iob_addr == ADDR_STATUS);

  // Level counts the FIFO contents plus the beat held in the output register,
  // so free space is judged against the whole block.
  assign level      = fifo_cnt + LVL_W'(tvalid);
  assign free_beats = LVL_W'(DEPTH) - level;
  assign full       = free_beats < LVL_W'(N);
  assign empty      = (level == '0);
  assign pkt_busy   = (beat_cnt != '0);

  // A whole word is accepted or dropped. Partial words are never pushed.
  assign push    = data_wr & ~full;
  assign drop    = data_wr & full;
  assign pkt_rej = pkt_wr & pkt_busy;

  assign hs   = tvalid & tready;
  assign load = (~tvalid | tready) & (fifo_cnt != '0);

  // The beat count that will apply to a beat loaded this cycle. This takes
  // into account the handshake of the current output beat.
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (hs && (pkt_len != '0))
      beat_cnt_nxt = tlast ? '0 : beat_cnt + PKT_LEN_W'(1);
  end

  assign last_nxt = (pkt_len != '0) && (beat_cnt_nxt == pkt_len - PKT_LEN_W'(1));

  // ---- FIFO stage -----------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push)
      for (int i = 0; i < N; i++)
        mem[wr_ptr + FIFO_DEPTH_LOG2'(i)] <= iob_wdata[i*TDATA_W +: TDATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(N);
      if (load) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (push ? LVL_W'(N) : '0) - (load ? LVL_W'(1) : '0);
    end
  end

  // ---- Output register stage ------------------------------------------------
  // tlast is fixed when a beat is loaded. While the beat is stalled, tlast stays
  // stable together with tdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      tdata    <= '0;
      beat_cnt <= '0;
    end else if (flush) begin
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt_nxt;
      if (load) begin
        tvalid <= 1'b1;
        tdata  <= mem[rd_ptr];
        tlast  <= last_nxt;
      end else if (hs) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
    end
  end

  // ---- Control / status registers ------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_len  <= '0;
      thresh   <= '1;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (pkt_wr && !pkt_busy) pkt_len <= iob_wdata[PKT_LEN_W-1:0];
      if (thresh_wr)           thresh  <= iob_wdata[LVL_W-1:0];
      if (drop || pkt_rej)     overflow <= 1'b1;
      else if (status_rd)      overflow <= 1'b0;
      irq <= (level >= thresh);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (iob_addr)
      ADDR_PKT_LEN: rd_mux = DATA_W'(pkt_len);
      ADDR_THRESH:  rd_mux = DATA_W'(thresh);
      ADDR_STATUS:  rd_mux = DATA_W'(pack_status(overflow, pkt_busy, full, empty, level));
      default:      rd_mux = '0;
    endcase
  end

  // ---- Read response stage --------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iob_rvalid <= 1'b0;
      iob_rdata  <= '0;
    end else begin
      iob_rvalid <= rd_en;
      iob_rdata  <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_iob_axistream_out_pkt.sv
module tb_iob_axistream_out_pkt;

  logic        clk = 1'b0;
  logic        rst;
  logic        iob_avalid;
  logic [2:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_rvalid;
  logic [31:0] iob_rdata;
  logic        iob_ready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_d [$];
  bit         got_l [$];

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  iob_axistream_out_pkt #(
    .DATA_W(32), .TDATA_W(8), .FIFO_DEPTH_LOG2(4), .PKT_LEN_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata),
    .iob_wstrb(iob_wstrb), .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata),
    .iob_ready(iob_ready),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    iob_avalid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = 4'hF;
    tick;
    iob_avalid = 1'b0; iob_wstrb = 4'h0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    iob_avalid = 1'b1; iob_addr = a; iob_wstrb = 4'h0;
    tick;
    iob_avalid = 1'b0;
    d = iob_rdata;
    v = iob_rvalid;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    cpu_read(a, d, v);
    check({name, "_rvalid"}, {31'b0, v}, 32'd1);
    check(name, d, exp);
  endtask

  // Holds tready high for a fixed number of cycles and records every handshaked beat.
  task automatic drain(input int cycles);
    got_d.delete();
    got_l.delete();
    tready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (tvalid) begin
        got_d.push_back(tdata);
        got_l.push_back(tlast);
      end
      tick;
    end
    tready = 1'b0;
  endtask

  task automatic t4_writer;
    int          k = 0;
    int          polls = 0;
    logic [31:0] st;
    logic        v;
    while (k < 25 && polls < 3000) begin
      cpu_read(3'd3, st, v);
      polls++;
      if (!st[6]) begin
        cpu_write(3'd0, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        k++;
      end
    end
    check("t4_words_written", k, 25);
  endtask

  task automatic t4_consumer;
    int         beats = 0;
    int         nlast = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    for (int c = 0; c < 4000 && beats < 100; c++) begin
      tready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        check("t4_hold_tvalid", {31'b0, tvalid}, 32'd1);
        check("t4_hold_tdata", {24'b0, tdata}, {24'b0, prev_d});
        check("t4_hold_tlast", {31'b0, tlast}, {31'b0, prev_l});
      end
      if (tvalid && tready) begin
        check("t4_beat_data", {24'b0, tdata}, beats);
        check("t4_beat_last", {31'b0, tlast}, (beats == 99) ? 32'd1 : 32'd0);
        if (tlast) nlast++;
        beats++;
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      tick;
    end
    tready = 1'b0;
    check("t4_beat_count", beats, 100);
    check("t4_tlast_count", nlast, 1);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; tready = 1'b0;
    iob_avalid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;

    vecs[0]  = '{1'b0, 3'd1, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 3'd2, 32'h0,        32'h1F};
    vecs[2]  = '{1'b0, 3'd3, 32'h0,        32'h20};
    vecs[3]  = '{1'b0, 3'd5, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 3'd7, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3'd1, 32'h123,      32'h0};
    vecs[6]  = '{1'b0, 3'd1, 32'h0,        32'h123};
    vecs[7]  = '{1'b1, 3'd2, 32'h7,        32'h0};
    vecs[8]  = '{1'b0, 3'd2, 32'h0,        32'h7};
    vecs[9]  = '{1'b1, 3'd6, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{1'b0, 3'd6, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 3'd2, 32'h1F,       32'h0};
    vecs[12] = '{1'b0, 3'd2, 32'h0,        32'h1F};
    vecs[13] = '{1'b1, 3'd1, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 3'd1, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 3'd3, 32'h0,        32'h20};

    // Reset state
    #12;
    check("rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("rst_tlast", {31'b0, tlast}, 32'd0);
    check("rst_tdata", {24'b0, tdata}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_rvalid", {31'b0, iob_rvalid}, 32'd0);
    check("rst_rdata", iob_rdata, 32'd0);
    check("rst_ready", {31'b0, iob_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // Register vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdata);
      else read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // T1: streaming, latency and beat order
    tready = 1'b1;
    w = 32'h44332211;
    cpu_write(3'd0, w);
    check("t1_tvalid_t1", {31'b0, tvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("t1_tvalid_b%0d", i), {31'b0, tvalid}, 32'd1);
      check($sformatf("t1_tdata_b%0d", i), {24'b0, tdata}, {24'b0, w[i*8 +: 8]});
      check($sformatf("t1_tlast_b%0d", i), {31'b0, tlast}, 32'd0);
    end
    tick;
    check("t1_idle", {31'b0, tvalid}, 32'd0);
    tready = 1'b0;

    // T2: PKT_LEN=6 across two words
    cpu_write(3'd1, 32'd6);
    cpu_write(3'd0, 32'h04030201);
    cpu_write(3'd0, 32'h08070605);
    drain(12);
    check("t2_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      check($sformatf("t2_data%0d", i), {24'b0, got_d[i]}, i + 1);
      check($sformatf("t2_last%0d", i), {31'b0, got_l[i]}, (i == 5) ? 32'd1 : 32'd0);
    end
    read_chk("t2_status_busy", 3'd3, 32'h0A0);
    // PKT_LEN write mid-packet is rejected and flags overflow
    cpu_write(3'd1, 32'd3);
    read_chk("t5_pktlen_kept", 3'd1, 32'd6);
    read_chk("t5_status_ovf", 3'd3, 32'h1A0);
    read_chk("t5_status_clr", 3'd3, 32'h0A0);
    cpu_write(3'd0, 32'h0C0B0A09);
    drain(8);
    check("t2b_count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check($sformatf("t2b_data%0d", i), {24'b0, got_d[i]}, i + 9);
      check($sformatf("t2b_last%0d", i), {31'b0, got_l[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    read_chk("t2_status_idle", 3'd3, 32'h020);

    // T3: fill to full, drop a word, sticky overflow
    cpu_write(3'd1, 32'd0);
    for (int k = 0; k < 4; k++)
      cpu_write(3'd0, {8'(8'h43 + 4*k), 8'(8'h42 + 4*k), 8'(8'h41 + 4*k), 8'(8'h40 + 4*k)});
    read_chk("t3_status_full", 3'd3, 32'h050);
    cpu_write(3'd0, 32'hEEEEEEEE);
    read_chk("t3_status_ovf", 3'd3, 32'h150);
    read_chk("t3_status_clr", 3'd3, 32'h050);
    check("t3_stall_tvalid", {31'b0, tvalid}, 32'd1);
    check("t3_stall_tdata", {24'b0, tdata}, 32'h40);
    drain(24);
    check("t3_count", got_d.size(), 16);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      check($sformatf("t3_data%0d", i), {24'b0, got_d[i]}, 32'h40 + i);
      check($sformatf("t3_last%0d", i), {31'b0, got_l[i]}, 32'd0);
    end
    read_chk("t3_status_empty", 3'd3, 32'h020);

    // T4: 100-beat packet with random backpressure
    cpu_write(3'd1, 32'd100);
    fork
      t4_writer();
      t4_consumer();
    join
    read_chk("t4_status_end", 3'd3, 32'h020);

    // T5: threshold irq
    cpu_write(3'd2, 32'd8);
    cpu_write(3'd0, 32'h11111111);
    check("t5_irq_l4", {31'b0, irq}, 32'd0);
    cpu_write(3'd0, 32'h22222222);
    check("t5_irq_l8_same", {31'b0, irq}, 32'd0);
    tick;
    check("t5_irq_rise", {31'b0, irq}, 32'd1);
    tready = 1'b1;
    tick;
    tready = 1'b0;
    check("t5_irq_l7_same", {31'b0, irq}, 32'd1);
    tick;
    check("t5_irq_fall", {31'b0, irq}, 32'd0);
    read_chk("t5_status_l7", 3'd3, 32'h087);
    cpu_write(3'd4, 32'd0);
    check("t5_flush_tvalid", {31'b0, tvalid}, 32'd0);

    // T6: flush mid-packet with level 10
    cpu_write(3'd1, 32'd20);
    cpu_write(3'd0, 32'h33333333);
    cpu_write(3'd0, 32'h44444444);
    cpu_write(3'd0, 32'h55555555);
    tready = 1'b1;
    tick;
    tick;
    tready = 1'b0;
    read_chk("t6_status_l10", 3'd3, 32'h08A);
    check("t6_irq_before", {31'b0, irq}, 32'd1);
    cpu_write(3'd4, 32'h5A);
    check("t6_flush_tvalid", {31'b0, tvalid}, 32'd0);
    check("t6_flush_tlast", {31'b0, tlast}, 32'd0);
    read_chk("t6_status_flushed", 3'd3, 32'h020);
    check("t6_irq_after", {31'b0, irq}, 32'd0);
    read_chk("t6_pktlen_kept", 3'd1, 32'd20);
    read_chk("t6_thresh_kept", 3'd2, 32'd8);

    // Asynchronous reset pulse mid-stream
    cpu_write(3'd0, 32'hA5A5A5A5);
    tick;
    check("ar_pre_tvalid", {31'b0, tvalid}, 32'd1);
    check("ar_pre_tdata", {24'b0, tdata}, 32'hA5);
    iob_avalid = 1'b1; iob_addr = 3'd1; iob_wstrb = 4'h0;
    tick;
    iob_avalid = 1'b0;
    check("ar_pre_rvalid", {31'b0, iob_rvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_tvalid", {31'b0, tvalid}, 32'd0);
    check("ar_tdata", {24'b0, tdata}, 32'd0);
    check("ar_tlast", {31'b0, tlast}, 32'd0);
    check("ar_irq", {31'b0, irq}, 32'd0);
    check("ar_rvalid", {31'b0, iob_rvalid}, 32'd0);
    check("ar_rdata", iob_rdata, 32'd0);
    #2 rst = 1'b0;
    tick;
    read_chk("ar_status", 3'd3, 32'h020);
    read_chk("ar_pktlen", 3'd1, 32'd0);
    read_chk("ar_thresh", 3'd2, 32'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
